// File: rtl/xif_result_buffer.sv
// xif_result_buffer: commit-gated FIFO between the coprocessor execution FSM and the CV-X-IF result channel
// Ports: clk_i/rst_ni clock and async active-low reset; in_* push side from the execution FSM;
// commit_* commit/kill strobes from the core; result_* X-IF result channel; occupancy_o entry count.
module xif_result_buffer #(
  parameter int DEPTH = 4,
  parameter int ID_W  = 4
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic                     in_valid_i,
  output logic                     in_ready_o,
  input  logic [ID_W-1:0]          in_id_i,
  input  logic [4:0]               in_rd_i,
  input  logic [31:0]              in_data_i,
  input  logic                     in_we_i,
  input  logic                     commit_valid_i,
  input  logic [ID_W-1:0]          commit_id_i,
  input  logic                     commit_kill_i,
  output logic                     result_valid_o,
  input  logic                     result_ready_i,
  output logic [ID_W-1:0]          result_id_o,
  output logic [4:0]               result_rd_o,
  output logic [31:0]              result_data_o,
  output logic                     result_we_o,
  output logic [$clog2(DEPTH):0]   occupancy_o
);
  localparam int AW  = $clog2(DEPTH);
  localparam int NID = 1 << ID_W;
  logic [AW:0]      r_wr_ptr, r_rd_ptr, w_occ;
  logic [ID_W-1:0]  r_id [DEPTH];
  logic [4:0]       r_rd [DEPTH];
  logic [31:0]      r_data [DEPTH];
  logic [DEPTH-1:0] r_we;
  logic [NID-1:0]   r_cmt, r_kil, w_hmask, w_cmask, w_clr, w_set_c, w_set_k;
  logic             r_busy;
  logic [AW-1:0]    w_wa, w_ra;
  logic [ID_W-1:0]  w_hid;
  logic             w_full, w_empty, w_push, w_pop, w_drop;
  assign w_occ       = r_wr_ptr - r_rd_ptr;
  assign w_full      = w_occ == (AW+1)'(DEPTH);
  assign w_empty     = w_occ == '0;
  assign w_wa        = r_wr_ptr[AW-1:0];
  assign w_ra        = r_rd_ptr[AW-1:0];
  assign w_hid       = r_id[w_ra];
  assign w_hmask     = NID'(1) << w_hid;
  assign w_cmask     = NID'(1) << commit_id_i;
  // r_busy marks a transfer already on the bus, so a late kill cannot retract it
  assign result_valid_o = !w_empty && ((r_cmt[w_hid] && !r_kil[w_hid]) || r_busy);
  assign w_drop      = !w_empty && r_kil[w_hid] && !r_busy;
  assign w_pop       = result_valid_o && result_ready_i;
  assign w_push      = in_valid_i && !w_full;
  assign in_ready_o  = !w_full;
  assign occupancy_o = w_occ;
  assign result_id_o   = w_hid;
  assign result_rd_o   = r_rd[w_ra];
  assign result_data_o = r_data[w_ra];
  assign result_we_o   = r_we[w_ra];
  // clear is applied before set so a same-cycle commit on the retiring id survives
  assign w_clr   = (w_pop || w_drop) ? w_hmask : '0;
  assign w_set_c = (commit_valid_i && !commit_kill_i) ? w_cmask : '0;
  assign w_set_k = (commit_valid_i && commit_kill_i) ? w_cmask : '0;
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_cmt    <= '0;
      r_kil    <= '0;
      r_busy   <= 1'b0;
      r_we     <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        r_id[i]   <= '0;
        r_rd[i]   <= '0;
        r_data[i] <= '0;
      end
    end else begin
      if (w_push) begin
        r_id[w_wa]   <= in_id_i;
        r_rd[w_wa]   <= in_rd_i;
        r_data[w_wa] <= in_data_i;
        r_we[w_wa]   <= in_we_i;
        r_wr_ptr     <= r_wr_ptr + (AW+1)'(1);
      end
      if (w_pop || w_drop) r_rd_ptr <= r_rd_ptr + (AW+1)'(1);
      r_cmt  <= (r_cmt & ~w_clr) | w_set_c;
      r_kil  <= (r_kil & ~w_clr) | w_set_k;
      r_busy <= result_valid_o && !result_ready_i;
    end
  end
endmodule

// File: doc/xif_result_buffer.md
Name: xif_result_buffer

Overview:
- Buffers coprocessor results (id, rd, data, we) between the coprocessor execution FSM and the CV-X-IF result channel.
- Gates each result on the core's commit decision. Committed results are presented on the result interface in push order; killed results are dropped silently.
- Frees the execution FSM to accept a new offload while earlier results wait for commit or for result_ready.

Parameters:
- DEPTH, 4: number of result entries; must be a power of two, at least 2.
- ID_W, 4: width of the X-IF instruction id.

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  reset, asynchronous, active-low
- in_valid_i  in  1  result push request from the execution FSM
- in_ready_o  out  1  buffer can accept a push
- in_id_i  in  ID_W  instruction id of the pushed result
- in_rd_i  in  5  destination register
- in_data_i  in  32  result data
- in_we_i  in  1  register write enable for this result
- commit_valid_i  in  1  commit transaction strobe
- commit_id_i  in  ID_W  id being committed or killed
- commit_kill_i  in  1  1 = kill, 0 = commit
- result_valid_o  out  1  X-IF result_valid
- result_ready_i  in  1  X-IF result_ready
- result_id_o  out  ID_W  id of the head entry
- result_rd_o  out  5  rd of the head entry
- result_data_o  out  32  data of the head entry
- result_we_o  out  1  we of the head entry
- occupancy_o  out  clog2(DEPTH)+1  number of valid entries

Behaviour:
- Storage
  - Circular FIFO with wr_ptr and rd_ptr, each clog2(DEPTH)+1 bits wide; the MSB distinguishes full from empty.
  - Pointers wrap modulo 2*DEPTH.
  - occupancy = wr_ptr - rd_ptr.
  - full = (occupancy == DEPTH); empty = (occupancy == 0).
- Push
  - Occurs when in_valid_i && in_ready_o.
  - in_ready_o = !full, taken combinationally from registered state. There is no bypass: a full buffer refuses a push even when a pop happens in the same cycle.
- Commit table
  - Two flag vectors, cmt[2^ID_W] and kil[2^ID_W], indexed by id.
  - On commit_valid_i, set cmt[commit_id_i] if commit_kill_i = 0, otherwise set kil[commit_id_i].
  - A commit may arrive before, in the same cycle as, or after the push of that id; all three cases must work identically.
- Head decision, evaluated each cycle when not empty (h = head id):
  - kil[h] = 1: drop the head. rd_ptr advances, kil[h] and cmt[h] clear, result_valid_o stays 0 that cycle. Each drop costs 1 cycle.
  - cmt[h] = 1 and kil[h] = 0: result_valid_o = 1. Pop on result_valid_o && result_ready_i, which clears cmt[h].
  - Neither flag set: hold, with result_valid_o = 0.
- Result channel
  - result_valid_o is combinational from registered state only; it never depends on result_ready_i.
  - Once asserted, result_valid_o and all result_* fields stay stable until the handshake completes.
  - A kill for the head id arriving while result_valid_o = 1 is a protocol violation. It is ignored for the current transfer; the flag is still recorded and cleared on pop.
- Simultaneous events
  - A set caused by commit_valid_i and a clear caused by pop/drop on the same id in the same cycle: the set wins.
  - Push and pop in the same cycle: occupancy is unchanged.
  - A commit on a non-head id in the same cycle as a head pop: both take effect.
- Latency
  - A push whose id is already committed reaches result_valid_o = 1 in the cycle after the push, provided the buffer was empty.
  - A commit for the head id raises result_valid_o in the cycle after commit_valid_i.
- Reset (asynchronous, any time, including mid-transfer)
  - Pointers = 0; all cmt and kil flags = 0.
  - result_valid_o = 0, in_ready_o = 1, occupancy_o = 0.
  - result_id_o, result_rd_o, result_data_o, result_we_o = 0, because entry storage is reset.
- Empty buffer: result_valid_o = 0; no drop or pop occurs. Flags may still be set by commits.

Test Plan:
- Commit before push: commit id=3 kill=0, then push id=3 rd=5 data=0x12345678 -> result_valid_o=1 the next cycle with id=3, rd=5, data=0x12345678; with result_ready_i=1, occupancy returns to 0 and cmt[3]=0.
- Kill drop: push id=1 then id=2, kill id=1, commit id=2 -> id=1 is never presented; exactly one idle cycle, then id=2 is presented.
- Full/back-pressure: push ids 0..3 with result_ready_i=0 -> in_ready_o=0 and occupancy_o=4. A fifth push is refused. Commit all and release ready -> results appear in order 0,1,2,3 on consecutive cycles.
- Stall stability: head is committed and result_ready_i is held 0 for 5 cycles -> result_valid_o and all result_* fields are constant; a push during the stall does not alter them.
- Pointer wrap: 10 push/commit/pop cycles of ids 0..9 mod 16 -> every result is delivered in order, and occupancy never exceeds 1 with ready held high.
- Reset mid-operation: occupancy 3 with result_valid_o=1, assert rst_ni=0 -> result_valid_o=0, in_ready_o=1, occupancy_o=0 immediately; after release, no stale entry or flag produces a result.
